// File: rtl/timer_alarm_sched_pkg.sv
// Shared definitions for the alarm scheduler: configuration op codes, scan FSM
// encodings and the derived time width.
package timer_alarm_sched_pkg;

   localparam logic [1:0] ALARM_OP_NOP    = 2'd0;
   localparam logic [1:0] ALARM_OP_ARM    = 2'd1;
   localparam logic [1:0] ALARM_OP_DISARM = 2'd2;
   localparam logic [1:0] ALARM_OP_ACK    = 2'd3;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_SAMPLE = 2'd1;
   localparam logic [1:0] ST_WAIT   = 2'd2;
   localparam logic [1:0] ST_CMP    = 2'd3;

   function automatic int alarm_time_w(input int data_w);
      return 2 * data_w;
   endfunction

endpackage

// File: rtl/timer_alarm_sched_ch.sv
// One alarm channel: deadline, reload period, armed and pending state, plus the
// periodic reload adder applied when the shared comparator reports a hit.
module timer_alarm_ch
   import timer_alarm_sched_pkg::*;
#(
   parameter int TIME_W = 64
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cfg_we_i,
   input  logic [1:0]        cfg_op_i,
   input  logic [TIME_W-1:0] cfg_deadline_i,
   input  logic [TIME_W-1:0] cfg_period_i,
   input  logic              cmp_en_i,
   input  logic              fire_i,
   output logic [TIME_W-1:0] deadline_o,
   output logic              armed_o,
   output logic              pending_o
);

   logic [TIME_W-1:0] deadline_q, deadline_d;
   logic [TIME_W-1:0] period_q, period_d;
   logic              armed_q, armed_d;
   logic              pending_q, pending_d;

   // Next-state: configuration has priority; a hit on a periodic channel
   // advances by exactly one period (no catch-up), a one-shot disarms.
   always_comb begin
      deadline_d = deadline_q;
      period_d   = period_q;
      armed_d    = armed_q;
      pending_d  = pending_q;
      if (cfg_we_i) begin
         case (cfg_op_i)
            ALARM_OP_ARM: begin
               armed_d    = 1'b1;
               pending_d  = 1'b0;
               deadline_d = cfg_deadline_i;
               period_d   = cfg_period_i;
            end
            ALARM_OP_DISARM: begin
               armed_d   = 1'b0;
               pending_d = 1'b0;
            end
            ALARM_OP_ACK:    pending_d = 1'b0;
            ALARM_OP_NOP:    pending_d = pending_q;
            default:         pending_d = pending_q;
         endcase
      end else if (cmp_en_i && fire_i && armed_q) begin
         pending_d = 1'b1;
         if (period_q != {TIME_W{1'b0}}) begin
            deadline_d = deadline_q + period_q;
         end else begin
            armed_d = 1'b0;
         end
      end else begin
         pending_d = pending_q;
      end
   end

   // Channel state registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         deadline_q <= {TIME_W{1'b0}};
         period_q   <= {TIME_W{1'b0}};
         armed_q    <= 1'b0;
         pending_q  <= 1'b0;
      end else begin
         deadline_q <= deadline_d;
         period_q   <= period_d;
         armed_q    <= armed_d;
         pending_q  <= pending_d;
      end
   end

   assign deadline_o = deadline_q;
   assign armed_o    = armed_q;
   assign pending_o  = pending_q;

endmodule

// File: rtl/timer_alarm_sched.sv
// Alarm scheduler top: owns timer enable/sample, scans the channels through a
// single time-multiplexed comparator and aggregates the interrupt.
module timer_alarm_sched
   import timer_alarm_sched_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int N_CH   = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      sched_en,
   output logic                      timer_enable,
   output logic                      timer_sample,
   input  logic [2*DATA_W-1:0]       timer_value,
   input  logic                      cfg_valid,
   output logic                      cfg_ready,
   input  logic [$clog2(N_CH)-1:0]   cfg_ch,
   input  logic [1:0]                cfg_op,
   input  logic [2*DATA_W-1:0]       cfg_deadline,
   input  logic [2*DATA_W-1:0]       cfg_period,
   input  logic [N_CH-1:0]           irq_mask,
   output logic [N_CH-1:0]           armed,
   output logic [N_CH-1:0]           pending,
   output logic                      irq
);

   localparam int TIME_W = alarm_time_w(DATA_W);
   localparam int IDX_W  = $clog2(N_CH);

   logic [1:0]       state_q, state_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic             enable_q, sample_q, ready_q, irq_q;
   logic             last_s, cfg_xfer_s, hit_s;
   logic [TIME_W-1:0] dl_s [N_CH];
   logic [N_CH-1:0]   armed_s, pending_s;

   assign last_s     = (idx_q == IDX_W'(N_CH - 1));
   assign cfg_xfer_s = cfg_valid && ready_q;
   assign hit_s      = (timer_value >= dl_s[idx_q]);

   // Scan FSM: sample, let the timer register capture, then one compare per cycle.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      case (state_q)
         ST_IDLE: begin
            if (sched_en) begin
               state_d = ST_SAMPLE;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_SAMPLE: state_d = ST_WAIT;
         ST_WAIT: begin
            state_d = ST_CMP;
            idx_d   = {IDX_W{1'b0}};
         end
         ST_CMP: begin
            if (last_s) begin
               idx_d   = {IDX_W{1'b0}};
               state_d = sched_en ? ST_SAMPLE : ST_IDLE;
            end else begin
               idx_d = idx_q + IDX_W'(1);
            end
         end
         default: begin
            state_d = ST_IDLE;
            idx_d   = {IDX_W{1'b0}};
         end
      endcase
   end

   // Outputs are decoded from the next state so they line up with state_q.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         idx_q    <= {IDX_W{1'b0}};
         enable_q <= 1'b0;
         sample_q <= 1'b0;
         ready_q  <= 1'b0;
         irq_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         enable_q <= sched_en;
         sample_q <= (state_d == ST_SAMPLE);
         ready_q  <= (state_d != ST_CMP);
         irq_q    <= |(pending_s & irq_mask);
      end
   end

   for (genvar i = 0; i < N_CH; i++) begin : g_ch
      timer_alarm_ch #(
         .TIME_W(TIME_W)
      ) u_ch (
         .clk           (clk),
         .rst           (rst),
         .cfg_we_i      (cfg_xfer_s && (cfg_ch == IDX_W'(i))),
         .cfg_op_i      (cfg_op),
         .cfg_deadline_i(cfg_deadline),
         .cfg_period_i  (cfg_period),
         .cmp_en_i      ((state_q == ST_CMP) && (idx_q == IDX_W'(i))),
         .fire_i        (hit_s),
         .deadline_o    (dl_s[i]),
         .armed_o       (armed_s[i]),
         .pending_o     (pending_s[i])
      );
   end

   assign timer_enable = enable_q;
   assign timer_sample = sample_q;
   assign cfg_ready    = ready_q;
   assign armed        = armed_s;
   assign pending      = pending_s;
   assign irq          = irq_q;

endmodule

// File: tb/tb_timer_alarm_sched.sv
// Directed bench for timer_alarm_sched: a vector table of config op + one scan
// sample with expected flags, plus hand sequences for reset and FSM timing.
module tb_timer_alarm_sched;

   localparam int DATA_W = 32;
   localparam int N_CH   = 4;
   localparam logic [1:0] OP_NOP = 2'd0, OP_ARM = 2'd1, OP_DIS = 2'd2, OP_ACK = 2'd3;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        sched_en = 1'b0;
   logic        timer_enable, timer_sample, cfg_ready, irq;
   logic [63:0] timer_value = 64'd0;
   logic        cfg_valid = 1'b0;
   logic [1:0]  cfg_ch = 2'd0;
   logic [1:0]  cfg_op = 2'd0;
   logic [63:0] cfg_deadline = 64'd0;
   logic [63:0] cfg_period = 64'd0;
   logic [3:0]  irq_mask = 4'b1111;
   logic [3:0]  armed, pending;

   int checks = 0;
   int errors = 0;

   timer_alarm_sched #(.DATA_W(DATA_W), .N_CH(N_CH)) dut (
      .clk(clk), .rst(rst), .sched_en(sched_en),
      .timer_enable(timer_enable), .timer_sample(timer_sample),
      .timer_value(timer_value), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
      .cfg_ch(cfg_ch), .cfg_op(cfg_op), .cfg_deadline(cfg_deadline),
      .cfg_period(cfg_period), .irq_mask(irq_mask), .armed(armed),
      .pending(pending), .irq(irq)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]  op;
      logic [1:0]  ch;
      logic [63:0] dl;
      logic [63:0] per;
      logic [3:0]  mask;
      logic [63:0] tv;
      logic [3:0]  exp_armed;
      logic [3:0]  exp_pend;
      logic        exp_irq;
   } vec_t;

   vec_t vecs [20];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic do_cfg(input logic [1:0] op, input logic [1:0] ch,
                         input logic [63:0] dl, input logic [63:0] per);
      int n = 0;
      cfg_valid = 1'b1; cfg_op = op; cfg_ch = ch; cfg_deadline = dl; cfg_period = per;
      while (!cfg_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("cfg_ready_seen", {63'd0, cfg_ready}, 64'd1);
      @(negedge clk);
      cfg_valid = 1'b0; cfg_op = OP_NOP;
   endtask

   // Present tv for exactly one scan; return on the next SAMPLE cycle.
   task automatic scan(input logic [63:0] tv);
      int n = 0;
      while (!timer_sample && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("sample_seen", {63'd0, timer_sample}, 64'd1);
      timer_value = tv;
      repeat (N_CH + 2) @(negedge clk);
      timer_value = 64'd0;
   endtask

   initial begin
      int k;
      int seen;
      vecs[0]  = '{OP_ARM, 2'd0, 64'd100, 64'd0,  4'b1111, 64'd50,  4'b0001, 4'b0000, 1'b0};
      vecs[1]  = '{OP_NOP, 2'd0, 64'd0,   64'd0,  4'b1111, 64'd99,  4'b0001, 4'b0000, 1'b0};
      vecs[2]  = '{OP_NOP, 2'd0, 64'd0,   64'd0,  4'b0001, 64'd100, 4'b0000, 4'b0001, 1'b1};
      vecs[3]  = '{OP_ACK, 2'd0, 64'd0,   64'd0,  4'b1111, 64'd100, 4'b0000, 4'b0000, 1'b0};
      vecs[4]  = '{OP_ARM, 2'd2, 64'd50,  64'd40, 4'b1111, 64'd49,  4'b0100, 4'b0000, 1'b0};
      vecs[5]  = '{OP_NOP, 2'd0, 64'd0,   64'd0,  4'b1011, 64'd50,  4'b0100, 4'b0100, 1'b0};
      vecs[6]  = '{OP_ACK, 2'd2, 64'd0,   64'd0,  4'b1111, 64'd89,  4'b0100, 4'b0000, 1'b0};
      vecs[7]  = '{OP_NOP, 2'd0, 64'd0,   64'd0,  4'b1111, 64'd90,  4'b0100, 4'b0100, 1'b1};
      vecs[8]  = '{OP_ACK, 2'd2, 64'd0,   64'd0,  4'b1111, 64'd129, 4'b0100, 4'b0000, 1'b0};
      vecs[9]  = '{OP_NOP, 2'd0, 64'd0,   64'd0,  4'b1111, 64'd130, 4'b0100, 4'b0100, 1'b1};
      vecs[10] = '{OP_ACK, 2'd2, 64'd0,   64'd0,  4'b1111, 64'd300, 4'b0100, 4'b0100, 1'b1};
      vecs[11] = '{OP_ACK, 2'd2, 64'd0,   64'd0,  4'b1111, 64'd300, 4'b0100, 4'b0100, 1'b1};
      vecs[12] = '{OP_ACK, 2'd2, 64'd0,   64'd0,  4'b1111, 64'd300, 4'b0100, 4'b0100, 1'b1};
      vecs[13] = '{OP_ACK, 2'd2, 64'd0,   64'd0,  4'b1111, 64'd300, 4'b0100, 4'b0100, 1'b1};
      vecs[14] = '{OP_ACK, 2'd2, 64'd0,   64'd0,  4'b1111, 64'd300, 4'b0100, 4'b0000, 1'b0};
      vecs[15] = '{OP_DIS, 2'd2, 64'd0,   64'd0,  4'b1111, 64'd0,   4'b0000, 4'b0000, 1'b0};
      vecs[16] = '{OP_ARM, 2'd3, 64'hFFFF_FFFF_FFFF_FFF0, 64'h20, 4'b1111,
                   64'hFFFF_FFFF_FFFF_FFEF, 4'b1000, 4'b0000, 1'b0};
      vecs[17] = '{OP_NOP, 2'd0, 64'd0,   64'd0,  4'b1111, 64'hFFFF_FFFF_FFFF_FFF0,
                   4'b1000, 4'b1000, 1'b1};
      vecs[18] = '{OP_ACK, 2'd3, 64'd0,   64'd0,  4'b1111, 64'h0F,  4'b1000, 4'b0000, 1'b0};
      vecs[19] = '{OP_NOP, 2'd0, 64'd0,   64'd0,  4'b1111, 64'h10,  4'b1000, 4'b1000, 1'b1};

      // Reset state, then idle with the scheduler stopped.
      @(negedge clk);
      chk("reset_outputs", {50'd0, timer_enable, timer_sample, cfg_ready, armed, pending, irq}, 64'd0);
      rst = 1'b0;
      @(negedge clk);
      chk("idle_ready", {62'd0, cfg_ready, timer_sample}, 64'd2);

      // Enable latency and scan period.
      sched_en = 1'b1;
      chk("enable_before", {63'd0, timer_enable}, 64'd0);
      @(negedge clk);
      chk("enable_after", {62'd0, timer_enable, timer_sample}, 64'd3);
      for (int s = 0; s < 2; s++) begin
         k = 0;
         do begin
            @(negedge clk);
            k++;
         end while (!timer_sample && k < 20);
         chk("scan_period", k, 64'd6);
      end

      // Config request during CMP stalls until the next SAMPLE.
      repeat (2) @(negedge clk);
      cfg_valid = 1'b1; cfg_op = OP_ARM; cfg_ch = 2'd1; cfg_deadline = 64'd1000; cfg_period = 64'd0;
      chk("ready_in_cmp", {63'd0, cfg_ready}, 64'd0);
      k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (!cfg_ready && k < 20);
      chk("cfg_stall_cycles", k, 64'd4);
      chk("no_change_in_cmp", {60'd0, armed}, 64'd0);
      @(negedge clk);
      cfg_valid = 1'b0; cfg_op = OP_NOP;
      chk("cfg_after_sample", {60'd0, armed}, 64'b0010);

      // Reset in the middle of a scan with channel 1 armed.
      repeat (2) @(negedge clk);
      rst = 1'b1;
      sched_en = 1'b0;
      @(negedge clk);
      chk("midscan_reset", {50'd0, timer_enable, timer_sample, cfg_ready, armed, pending, irq}, 64'd0);
      rst = 1'b0;
      seen = 0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (timer_sample || armed != 4'd0) seen++;
      end
      chk("idle_after_reset", seen, 64'd0);

      // Table: one config op then one scan with a fixed sample.
      sched_en = 1'b1;
      for (int i = 0; i < 20; i++) begin
         irq_mask = vecs[i].mask;
         if (vecs[i].op != OP_NOP) do_cfg(vecs[i].op, vecs[i].ch, vecs[i].dl, vecs[i].per);
         scan(vecs[i].tv);
         chk($sformatf("armed_v%0d", i), {60'd0, armed}, {60'd0, vecs[i].exp_armed});
         chk($sformatf("pending_v%0d", i), {60'd0, pending}, {60'd0, vecs[i].exp_pend});
         @(negedge clk);
         chk($sformatf("irq_v%0d", i), {63'd0, irq}, {63'd0, vecs[i].exp_irq});
      end

      // Dropping sched_en mid-scan: scan completes, then FSM stays idle.
      do_cfg(OP_ACK, 2'd3, 64'd0, 64'd0);
      k = 0;
      while (!timer_sample && k < 20) begin
         @(negedge clk);
         k++;
      end
      chk("sample_before_drop", {63'd0, timer_sample}, 64'd1);
      timer_value = 64'h40;
      repeat (3) @(negedge clk);
      sched_en = 1'b0;
      @(negedge clk);
      chk("enable_drop", {63'd0, timer_enable}, 64'd0);
      repeat (2) @(negedge clk);
      chk("scan_completes", {60'd0, pending}, 64'b1000);
      timer_value = 64'd0;
      seen = 0;
      for (int c = 0; c < 12; c++) begin
         if (timer_sample) seen++;
         @(negedge clk);
      end
      chk("stopped_no_sample", seen, 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
